r2mdc_commutator: RTL and testbench
===================================

# r2mdc_commutator

Delay-commutator stage of the R2MDC FFT pipeline, sitting directly upstream of the radix-2 butterfly. It takes two parallel complex streams (upper path in0, lower path in1) and delays and swaps them so that each output pair holds the two samples the butterfly must combine (A, B). It also emits the matching twiddle LUT index for each pair and frames the stream with a drain phase so that every frame yields exactly N/2 pairs. Samples are 16-bit signed, Q7.8 (1 sign, 7 integer, 8 fractional bits).

## Interface
- N, 16: FFT size in samples; power of two, ≥4.
- DELAY, 4: commutator delay D in pairs; power of two, ≥1; N/2 must be a multiple of 2·D.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input pair present.
- in_ready  out  1  block accepts the pair this cycle.
- in_last  in  1  marks the final pair of a frame.
- in0_re, in0_im  in  16 each  upper-path sample, signed Q7.8.
- in1_re, in1_im  in  16 each  lower-path sample, signed Q7.8.
- out_valid  out  1  output pair valid; no backpressure.
- out_last  out  1  final pair of the frame.
- out_a_re, out_a_im  out  16 each  butterfly input A (earlier sample).
- out_b_re, out_b_im  out  16 each  butterfly input B (later sample).
- out_tw_idx  out  log2(N/2)  twiddle LUT index for this pair.
- err_frame  out  1  sticky: in_last disagreed with the frame counter.

## Operation
- Accept = in_valid & in_ready. n is the accepted-pair index within the frame, 0..N/2−1. sw = (n mod 2D) ≥ D.
- Datapath: u = in0 delayed by D accepts. top = sw ? in1 : u; bot = sw ? u : in1. out_b = top; out_a = bot delayed by D accepts.
- Resulting pairs: when sw=1, (a,b) = (x1[n−D], x1[n]); when sw=0 and n ≥ 2D, (a,b) = (x0[n−2D], x0[n−D]).
- FSM states FILL, RUN, DRAIN:
  - FILL: accepts produce no output; go to RUN once D pairs have been accepted (n = D−1).
  - RUN: every accept produces one output. After the accept at n = N/2−1, go to DRAIN.
  - DRAIN: in_ready = 0 for D cycles. Zeros are injected as internal accepts at n = N/2..N/2+D−1, producing the final D x0 pairs. After the D-th drain cycle, return to FILL with n cleared.
- in_ready = 1 in FILL and RUN.
- Frame end is set by the counter only. err_frame sets if in_last=1 when n≠N/2−1, or in_last=0 when n=N/2−1. err_frame clears only on reset.
- out_tw_idx = (output pair count mod D) << log2(N/(2D)).
- out_last is set on the last drain output. Each frame yields exactly N/2 outputs.
- No arithmetic beyond the optional scaling; data are passed bit-exact.

## Timing
- Latency is 1 cycle: the outputs are registered and reflect the accept or drain step of the previous edge.
- out_valid is high for exactly one cycle per producing step. Gaps in in_valid stall the pipeline and produce no outputs.
- Reset values: all outputs 0, except in_ready, which is 1 (state FILL, n=0). Delay-line contents are unspecified after reset and are never emitted, because the FILL phase gates them.
- An async reset mid-frame or mid-drain aborts the frame immediately: the next cycle is FILL, and no out_last is issued for the aborted frame.
- Drain begins on the cycle after the last accept. The next frame's first accept can occur on the cycle after the final drain step.

## Configuration
- R2MDC_COMM_SCALE_EN defined: all four output components are arithmetic-shifted right by 1 (floor) before registering, giving a ½ per-stage scale to prevent butterfly overflow. Example: 0x0101 becomes 0x0080, and 0xFFFD becomes 0xFFFE.
- R2MDC_COMM_SCALE_EN undefined: data are passed unmodified.

## Test plan
Common setup: N=16, D=4, macro off, x0[k] re = k, x1[k] re = 16+k, im = −re, continuous in_valid, in_last on k=7.
- Basic frame -> outputs (a_re, b_re) = (16,20), (17,21), (18,22), (19,23), then drain (0,4), (1,5), (2,6), (3,7). Imaginary parts are the negated values. out_tw_idx follows 0,2,4,6 in each group. out_last on (3,7). Exactly 8 out_valid pulses.
- Latency and ready -> first out_valid occurs 1 cycle after the 5th accept. in_ready is low for exactly 4 cycles, starting the cycle after the k=7 accept.
- Random in_valid gaps on the same frame -> identical output sequence. out_valid is never asserted on a non-accept RUN cycle.
- in_last at k=5 -> err_frame rises 1 cycle later and stays high. Framing still ends at k=7.
- Assert rst_n low at k=6, then send a fresh frame -> no out_last for the aborted frame. The fresh frame matches the basic-frame output exactly.
- Macro defined, x1[0] re = 0x0101 and x1[4] re = 0xFFFD -> first output has a_re = 0x0080 and b_re = 0xFFFE.

Source files
------------

// File: rtl/r2mdc_commutator_if.sv
// r2mdc_commutator_if
// Handshake and data bundle of the R2MDC delay-commutator stage.
// master: the upstream producer (drives in_*, observes out_*).
// slave : the commutator itself.
interface r2mdc_commutator_if #(
  parameter int N = 16
);
  localparam int TW_W = $clog2(N / 2);

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [15:0]       in0_re;
  logic [15:0]       in0_im;
  logic [15:0]       in1_re;
  logic [15:0]       in1_im;

  logic              out_valid;
  logic              out_last;
  logic [15:0]       out_a_re;
  logic [15:0]       out_a_im;
  logic [15:0]       out_b_re;
  logic [15:0]       out_b_im;
  logic [TW_W-1:0]   out_tw_idx;
  logic              err_frame;

  modport master (
    output in_valid, in_last, in0_re, in0_im, in1_re, in1_im,
    input  in_ready, out_valid, out_last, out_a_re, out_a_im,
           out_b_re, out_b_im, out_tw_idx, err_frame
  );

  modport slave (
    input  in_valid, in_last, in0_re, in0_im, in1_re, in1_im,
    output in_ready, out_valid, out_last, out_a_re, out_a_im,
           out_b_re, out_b_im, out_tw_idx, err_frame
  );
endinterface

// File: rtl/r2mdc_commutator.sv
// r2mdc_commutator
// Delay-commutator stage feeding the radix-2 butterfly of an R2MDC FFT.
// The upper stream is delayed by DELAY pairs, the two streams are swapped
// every DELAY pairs, and the swapped lower stream is delayed again so each
// output pair holds the two samples one butterfly combines. After the last
// pair of a frame, DELAY zero pairs are injected internally (drain) so the
// frame always yields N/2 outputs.
// Optional macro: R2MDC_COMM_SCALE_EN -- halves every output component
// (arithmetic shift right by one) to give headroom in the butterfly.
module r2mdc_commutator #(
  parameter int N     = 16,
  parameter int DELAY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  r2mdc_commutator_if.slave    bus
);

  localparam int HALF     = N / 2;
  localparam int CNT_W    = $clog2(HALF + DELAY);
  localparam int TW_W     = $clog2(HALF);
  localparam int TW_SHIFT = $clog2(N / (2 * DELAY));
  localparam int SW_BIT   = $clog2(DELAY);

  localparam logic [CNT_W-1:0] FILL_END  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] LAST_N    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(HALF + DELAY - 1);
  localparam logic [CNT_W-1:0] MOD_MASK  = CNT_W'(DELAY - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] n_nxt;
  logic [CNT_W-1:0] n_mod;

  logic             accept;
  logic             step;
  logic             produce;
  logic             drain;
  logic             last_step;
  logic             err_set;
  logic             sw;

  logic [31:0]      samp0;
  logic [31:0]      samp1;
  logic [31:0]      u;
  logic [31:0]      top;
  logic [31:0]      bot;
  logic [TW_W-1:0]  tw_nxt;

  logic [31:0]      dl0 [DELAY];
  logic [31:0]      dla [DELAY];

  logic             out_valid_q;
  logic             out_last_q;
  logic [31:0]      out_a_q;
  logic [31:0]      out_b_q;
  logic [TW_W-1:0]  out_tw_q;
  logic             err_q;

  // Packed {re, im} pair scaling; the scaled variant floors toward -inf.
  function automatic logic [31:0] scale_pair(input logic [31:0] v);
`ifdef R2MDC_COMM_SCALE_EN
    return {v[31], v[31:17], v[15], v[15:1]};
`else
    return v;
`endif
  endfunction

  // The drain phase is the only time the block refuses input.
  assign bus.in_ready = (state != DRAIN);
  assign accept       = bus.in_valid && bus.in_ready;

  // Frame sequencing: FILL primes the delay lines, RUN emits one pair per
  // accept, DRAIN pushes zeros through to flush the last DELAY pairs.
  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    step      = 1'b0;
    produce   = 1'b0;
    drain     = 1'b0;
    last_step = 1'b0;
    err_set   = accept && (bus.in_last != (n == LAST_N));
    case (state)
      FILL: begin
        if (accept) begin
          step  = 1'b1;
          n_nxt = n + CNT_W'(1);
          if (n == FILL_END) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          step    = 1'b1;
          produce = 1'b1;
          n_nxt   = n + CNT_W'(1);
          if (n == LAST_N) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        step    = 1'b1;
        produce = 1'b1;
        drain   = 1'b1;
        if (n == DRAIN_END) begin
          last_step = 1'b1;
          n_nxt     = '0;
          state_nxt = FILL;
        end else begin
          n_nxt = n + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = FILL;
        n_nxt     = '0;
      end
    endcase
  end

  // Swap network: sw flips every DELAY pairs; drain steps feed zeros. The
  // output pair count within a frame is n - DELAY, so its residue mod DELAY
  // equals n mod DELAY and the twiddle index comes straight from n.
  always_comb begin
    samp0  = drain ? 32'h0 : {bus.in0_re, bus.in0_im};
    samp1  = drain ? 32'h0 : {bus.in1_re, bus.in1_im};
    u      = dl0[DELAY-1];
    sw     = n[SW_BIT];
    top    = sw ? samp1 : u;
    bot    = sw ? u : samp1;
    n_mod  = n & MOD_MASK;
    tw_nxt = TW_W'(n_mod) << TW_SHIFT;
  end

  // Delay lines advance on every accept or drain step; their contents are
  // never observable before FILL has overwritten them, so they need no reset.
  always_ff @(posedge clk) begin
    if (step) begin
      dl0[0] <= samp0;
      dla[0] <= bot;
      for (int i = 1; i < DELAY; i++) begin
        dl0[i] <= dl0[i-1];
        dla[i] <= dla[i-1];
      end
    end
  end

  // Control state, registered outputs and the sticky framing error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      n           <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_tw_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      n           <= n_nxt;
      out_valid_q <= produce;
      out_last_q  <= last_step;
      if (produce) begin
        out_a_q  <= scale_pair(dla[DELAY-1]);
        out_b_q  <= scale_pair(top);
        out_tw_q <= tw_nxt;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_a_re   = out_a_q[31:16];
  assign bus.out_a_im   = out_a_q[15:0];
  assign bus.out_b_re   = out_b_q[31:16];
  assign bus.out_b_im   = out_b_q[15:0];
  assign bus.out_tw_idx = out_tw_q;
  assign bus.err_frame  = err_q;

endmodule

// File: tb/tb_r2mdc_commutator.sv
// tb_r2mdc_commutator
// Scoreboard bench: the driver pushes expected pairs (with the cycle they
// must appear on) as it issues accepts; a negedge monitor pops and compares.
// Expected pairs come from the closed-form pairing rule of the commutator.
module tb_r2mdc_commutator;

  localparam int N    = 16;
  localparam int D    = 4;
  localparam int HALF = N / 2;
  localparam int TW_W = $clog2(HALF);

  typedef struct {
    int              cyc;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TW_W-1:0] tw;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic err_exp = 1'b0;

  logic [31:0] x0 [HALF];
  logic [31:0] x1 [HALF];
  exp_t        fexp [HALF];
  exp_t        exq [$];

  r2mdc_commutator_if #(.N(N)) bus ();

  r2mdc_commutator #(.N(N), .DELAY(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] scl(input logic [31:0] v);
`ifdef R2MDC_COMM_SCALE_EN
    logic signed [15:0] re;
    logic signed [15:0] im;
    re = $signed(v[31:16]) >>> 1;
    im = $signed(v[15:0]) >>> 1;
    return {re, im};
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] get0(input int i);
    return (i < HALF) ? x0[i] : 32'h0;
  endfunction

  function automatic logic [31:0] get1(input int i);
    return (i < HALF) ? x1[i] : 32'h0;
  endfunction

  // Output m combines stream samples around index n = m + D: when n falls in
  // the swapped half of a 2D window the lower stream pairs with itself D
  // apart, otherwise the upper stream pairs with itself D apart.
  task automatic build_model();
    for (int m = 0; m < HALF; m++) begin
      int n;
      n = m + D;
      if ((n % (2 * D)) >= D) begin
        fexp[m].a = scl(get1(n - D));
        fexp[m].b = scl(get1(n));
      end else begin
        fexp[m].a = scl(get0(n - 2 * D));
        fexp[m].b = scl(get0(n - D));
      end
      fexp[m].tw   = TW_W'((m % D) * (N / (2 * D)));
      fexp[m].last = (m == HALF - 1);
      fexp[m].cyc  = 0;
    end
  endtask

  task automatic load_pattern();
    for (int k = 0; k < HALF; k++) begin
      x0[k] = {16'(k), 16'(-k)};
      x1[k] = {16'(16 + k), 16'(-(16 + k))};
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < HALF; k++) begin
      x0[k] = $urandom;
      x1[k] = $urandom;
    end
    x1[0][31:16] = 16'h0101;
    x1[4][31:16] = 16'hFFFD;
  endtask

  // Drive one pair (after an optional idle gap) and register its expectations.
  task automatic apply_stimulus(input int k, input logic last, input int gap);
    int   w;
    int   c;
    exp_t e;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      #1;
    end
    {bus.in0_re, bus.in0_im} = x0[k];
    {bus.in1_re, bus.in1_im} = x1[k];
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) check_output("ready_timeout", 64'(bus.in_ready), 64'd1);
    c = cyc;
    if (k >= D) begin
      e = fexp[k - D];
      e.cyc = c + 1;
      exq.push_back(e);
    end
    if (k == HALF - 1) begin
      for (int j = 0; j < D; j++) begin
        e = fexp[HALF - D + j];
        e.cyc = c + 2 + j;
        exq.push_back(e);
      end
    end
    if (last != (k == HALF - 1)) err_exp = 1'b1;
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_output("err_frame", 64'(bus.err_frame), 64'(err_exp));
  endtask

  task automatic run_frame(input int max_gap, input int last_k, input int stop_k);
    build_model();
    for (int k = 0; k < stop_k; k++) begin
      apply_stimulus(k, (k == last_k), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    if (stop_k == HALF) begin
      for (int j = 0; j < D; j++) begin
        check_output("drain_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        #1;
      end
      check_output("ready_after_drain", 64'(bus.in_ready), 64'd1);
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_out_last", 64'(bus.out_last), 64'd0);
    check_output("rst_out_data", {bus.out_a_re, bus.out_a_im, bus.out_b_re, bus.out_b_im}, 64'd0);
    check_output("rst_tw_idx", 64'(bus.out_tw_idx), 64'd0);
    check_output("rst_err_frame", 64'(bus.err_frame), 64'd0);
    check_output("rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // Scoreboard monitor: overdue expectations are reported as timing errors,
  // every out_valid must match the head of the queue on the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        check_output("missing_output_cycle", 64'(cyc), 64'(exq[0].cyc));
        void'(exq.pop_front());
      end
      if (bus.out_valid) begin
        if (exq.size() == 0) begin
          check_output("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exq.pop_front();
          check_output("out_cycle", 64'(cyc), 64'(e.cyc));
          check_output("out_a", {bus.out_a_re, bus.out_a_im}, 64'(e.a));
          check_output("out_b", {bus.out_b_re, bus.out_b_im}, 64'(e.b));
          check_output("out_tw_idx", 64'(bus.out_tw_idx), 64'(e.tw));
          check_output("out_last", 64'(bus.out_last), 64'(e.last));
        end
      end else if (bus.out_last) begin
        check_output("out_last_without_valid", 64'(bus.out_last), 64'd0);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in0_re = '0; bus.in0_im = '0;
    bus.in1_re = '0; bus.in1_im = '0;
    #2;
    check_reset_values();
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] basic frame, continuous valid");
    load_pattern();
    run_frame(0, HALF - 1, HALF);

    $display("[TB] same frame with random valid gaps");
    run_frame(3, HALF - 1, HALF);

    $display("[TB] random data frame with gaps");
    load_random();
    run_frame(2, HALF - 1, HALF);

    $display("[TB] early in_last at k=5");
    load_pattern();
    run_frame(0, 5, HALF);

    $display("[TB] reset abort at k=6");
    run_frame(0, HALF - 1, 6);
    rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    check_reset_values();
    check_output("queue_empty_after_abort", 64'(exq.size()), 64'd0);
    exq.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] fresh frame after abort");
    run_frame(0, HALF - 1, HALF);

    $display("[TB] extra random frames");
    for (int f = 0; f < 3; f++) begin
      load_random();
      run_frame(2, HALF - 1, HALF);
    end

    repeat (4) @(negedge clk);
    #1;
    check_output("queue_drained", 64'(exq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
